mem_port_bridge: RTL and testbench
==================================

MEM_PORT_BRIDGE -- requirements
Module: mem_port_bridge

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of kernel BRAM-style ports.
REQ-002 SHALL have parameter ADDR_WID, default 14, word-address width per port.
REQ-003 SHALL have parameter DATA_WID, default 32, data width per port and per memory channel.
REQ-004 SHALL have parameter ADDR_SHIFT, default 2, the left shift from word address to byte address.
REQ-005 mod_clk  in  1  block clock (reset reset, asynchronous, active-high; clock mod_clk).
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 read_base, write_base  in  64 each  byte base addresses for reads and writes.
REQ-008 xfer_size  in  64  value copied to rd_size/wr_size on each request.
REQ-009 port_ce, port_we  in  NUM_PORTS each  per-port access enable and write enable.
REQ-010 port_addr  in  NUM_PORTS*ADDR_WID  packed word addresses, port 0 in the LSBs.
REQ-011 port_d  in  NUM_PORTS*DATA_WID  packed write data.
REQ-012 port_q  out  NUM_PORTS*DATA_WID  packed read data, one register per port.
REQ-013 kernel_ce  out  1  kernel clock enable; the kernel advances only on edges where it is 1.
REQ-014 kernel_done  in  1  kernel completion flag.
REQ-015 rd_req, rd_addr, rd_size  out  1/64/64  read request pulse, byte address and size.
REQ-016 rd_ready, rd_data  in  1/DATA_WID  read completion pulse and its data.
REQ-017 wr_req, wr_addr, wr_size, wr_data  out  1/64/64/DATA_WID  write request pulse, address, size and data.
REQ-018 wr_ready  in  1  write completion pulse.
REQ-019 done  out  1  one-cycle completion pulse.
REQ-020 access_count, stall_count  out  32 each  performance counters.

Function
REQ-021 SHALL implement states RUN, ISSUE, WAIT, FINISH and HALT; kernel_ce SHALL be a registered output equal to 1 only while in RUN.
REQ-022 In RUN, on each edge: SHALL latch pending[i]=port_ce[i] together with the we, addr and d of every port; if any pending bit is set, SHALL go to ISSUE.
REQ-023 In RUN, if kernel_done=1 and no port_ce bit is set, SHALL go to FINISH.
REQ-024 If kernel_done=1 in the same cycle as any port_ce bit, SHALL set done_pend, service all requests first, then go to FINISH instead of RUN.
REQ-025 ISSUE: SHALL select the lowest-index set pending bit i.
REQ-026 ISSUE, read: SHALL pulse rd_req for exactly one cycle with rd_addr=read_base+(addr_i<<ADDR_SHIFT) and rd_size=xfer_size.
REQ-027 ISSUE, write: SHALL pulse wr_req for exactly one cycle with wr_addr=write_base+(addr_i<<ADDR_SHIFT), wr_size=xfer_size and wr_data=d_i.
REQ-028 ISSUE SHALL then go to WAIT.
REQ-029 Address arithmetic SHALL be 64-bit unsigned and wrap modulo 2^64.
REQ-030 WAIT on a matching ready pulse: read SHALL load port_q[i]<=rd_data; SHALL clear pending[i].
REQ-031 After the ready pulse, SHALL go to ISSUE if pending bits remain, else to FINISH if done_pend is set, else to RUN.
REQ-032 Ready pulses not matching the outstanding request type, and all ready pulses outside WAIT, SHALL be ignored.
REQ-033 Exactly one memory transaction SHALL be outstanding at a time.
REQ-034 Same-address accesses in one cycle SHALL complete in ascending port order, so a port-0 write is visible to a port-1 read.
REQ-035 port_q[i] SHALL hold its value until the next completed read on port i, giving the kernel one-enabled-cycle read latency.
REQ-036 FINISH SHALL assert done for exactly one cycle, then go to HALT.
REQ-037 HALT SHALL hold kernel_ce=0 and ignore all inputs until reset.

Reset
REQ-038 Reset SHALL force state RUN and clear pending and done_pend.
REQ-039 Reset SHALL set kernel_ce=1 and clear done, rd_req and wr_req.
REQ-040 Reset SHALL set rd_addr, wr_addr, rd_size and wr_size to 0.
REQ-041 Reset SHALL set port_q to 0 and both counters to 0.
REQ-042 Reset mid-transaction SHALL abandon the outstanding request; a later stale ready pulse SHALL be ignored because the block is in RUN.

Configuration
REQ-043 With MEM_BRIDGE_STATS_EN defined: access_count SHALL increment per completed transaction and stall_count per cycle with kernel_ce=0 outside HALT, both saturating at 2^32-1.
REQ-044 Without MEM_BRIDGE_STATS_EN: both counters SHALL be tied to 0 and their counter logic omitted.

Verification
REQ-045 Single read: port 0 read, addr 5, read_base 0x1000; rd_ready after 3 cycles with 0xDEAD -> rd_addr 0x1014; port_q[0]=0xDEAD; kernel_ce back to 1 one cycle after rd_ready.
REQ-046 Dual access: port 0 write addr 3 d=7 and port 1 read addr 3 in the same cycle -> wr_req precedes rd_req; rd_addr=read_base+12; access_count=2.
REQ-047 Simultaneous done: kernel_done together with a port 1 write -> write serviced, then done pulses 1 cycle, then kernel_ce stays 0.
REQ-048 Reset mid-WAIT, then a stray rd_ready -> port_q unchanged at 0; kernel_ce=1; no request issued.
REQ-049 Wrap: read_base 0xFFFF_FFFF_FFFF_FFF0 with addr 8 -> rd_addr 0x0000_0000_0000_0010.
REQ-050 NUM_PORTS=4 with all four ports reading -> four rd_req pulses for ports 0..3 in order; stall_count is at least 8 with the macro defined, 0 without.

Source files
------------

// File: rtl/mem_port_bridge_if.sv
// mem_port_bridge_if
//   Memory-channel bundle between mem_port_bridge and an external memory
//   engine. One read channel and one write channel, each a single-cycle
//   request pulse with address/size (and data for writes), answered by a
//   single-cycle ready pulse (with data for reads).
//   master : the bridge (drives requests, receives ready/rd_data)
//   slave  : the memory engine
interface mem_port_bridge_if #(
  parameter int DATA_WID = 32
);
  logic                rd_req;
  logic [63:0]         rd_addr;
  logic [63:0]         rd_size;
  logic                rd_ready;
  logic [DATA_WID-1:0] rd_data;
  logic                wr_req;
  logic [63:0]         wr_addr;
  logic [63:0]         wr_size;
  logic [DATA_WID-1:0] wr_data;
  logic                wr_ready;

  modport master (
    output rd_req, rd_addr, rd_size,
    input  rd_ready, rd_data,
    output wr_req, wr_addr, wr_size, wr_data,
    input  wr_ready
  );

  modport slave (
    input  rd_req, rd_addr, rd_size,
    output rd_ready, rd_data,
    input  wr_req, wr_addr, wr_size, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/mem_port_bridge.sv
// mem_port_bridge
//   Bridges NUM_PORTS kernel BRAM-style ports onto one serial memory channel.
//   While the kernel runs (kernel_ce=1) every enabled port access is captured;
//   the kernel is then frozen and the captured accesses are issued one at a
//   time in ascending port order. port_q[i] is loaded when a read on port i
//   completes and holds until the next one.
//   Ports:
//     mod_clk, reset          clock, asynchronous active-high reset
//     read_base, write_base   64-bit byte base addresses
//     xfer_size               copied to rd_size / wr_size on each request
//     port_ce/we/addr/d/q     packed kernel ports, port 0 in the LSBs
//     kernel_ce, kernel_done  kernel clock enable / kernel completion flag
//     mem                     memory channel (mem_port_bridge_if.master)
//     done                    one-cycle completion pulse
//     access_count, stall_count  performance counters
//   Build option: define MEM_BRIDGE_STATS_EN to enable the counters;
//   otherwise both read as 0.
module mem_port_bridge #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WID   = 14,
  parameter int DATA_WID   = 32,
  parameter int ADDR_SHIFT = 2
) (
  input  logic                          mod_clk,
  input  logic                          reset,
  input  logic [63:0]                   read_base,
  input  logic [63:0]                   write_base,
  input  logic [63:0]                   xfer_size,
  input  logic [NUM_PORTS-1:0]          port_ce,
  input  logic [NUM_PORTS-1:0]          port_we,
  input  logic [NUM_PORTS*ADDR_WID-1:0] port_addr,
  input  logic [NUM_PORTS*DATA_WID-1:0] port_d,
  output logic [NUM_PORTS*DATA_WID-1:0] port_q,
  output logic                          kernel_ce,
  input  logic                          kernel_done,
  mem_port_bridge_if.master             mem,
  output logic                          done,
  output logic [31:0]                   access_count,
  output logic [31:0]                   stall_count
);
  localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [2:0] {ST_RUN, ST_ISSUE, ST_WAIT, ST_FINISH, ST_HALT} state_t;

  state_t                        state_q, state_d;
  logic [NUM_PORTS-1:0]          pending_q, pending_d;
  logic                          done_pend_q, done_pend_d;
  logic [NUM_PORTS-1:0]          we_q, we_d;
  logic [NUM_PORTS*ADDR_WID-1:0] addr_q, addr_d;
  logic [NUM_PORTS*DATA_WID-1:0] dat_q, dat_d;
  logic                          kernel_ce_q, kernel_ce_d;
  logic                          done_q, done_d;
  logic                          rd_req_q, rd_req_d, wr_req_q, wr_req_d;
  logic [63:0]                   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [63:0]                   rd_size_q, rd_size_d, wr_size_q, wr_size_d;
  logic [DATA_WID-1:0]           wr_data_q, wr_data_d;
  logic [NUM_PORTS*DATA_WID-1:0] port_q_q, port_q_d;

  // Lowest-index pending port; stays stable from ISSUE through WAIT because
  // pending only changes when that port's transaction completes.
  logic [SEL_W-1:0]     sel;
  logic                 sel_we;
  logic [ADDR_WID-1:0]  sel_addr;
  logic [DATA_WID-1:0]  sel_dat;
  logic [63:0]          sel_off;
  logic                 ready_hit;
  logic [NUM_PORTS-1:0] pend_clr;

  always_comb begin
    sel = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (pending_q[i]) sel = SEL_W'(i);
    end
    sel_we    = we_q[sel];
    sel_addr  = addr_q[sel*ADDR_WID +: ADDR_WID];
    sel_dat   = dat_q[sel*DATA_WID +: DATA_WID];
    sel_off   = 64'(sel_addr) << ADDR_SHIFT;
    // Only the ready of the outstanding request's kind counts.
    ready_hit = sel_we ? mem.wr_ready : mem.rd_ready;
    pend_clr  = pending_q;
    pend_clr[sel] = 1'b0;
  end

  // State register
  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (|port_ce)         state_d = ST_ISSUE;
        else if (kernel_done) state_d = ST_FINISH;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ready_hit) begin
          if (|pend_clr)        state_d = ST_ISSUE;
          else if (done_pend_q) state_d = ST_FINISH;
          else                  state_d = ST_RUN;
        end
      end
      ST_FINISH: state_d = ST_HALT;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_RUN;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    pending_d   = pending_q;
    done_pend_d = done_pend_q;
    we_d        = we_q;
    addr_d      = addr_q;
    dat_d       = dat_q;
    rd_req_d    = 1'b0;
    wr_req_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    wr_addr_d   = wr_addr_q;
    rd_size_d   = rd_size_q;
    wr_size_d   = wr_size_q;
    wr_data_d   = wr_data_q;
    port_q_d    = port_q_q;
    // Registered so the kernel sees the enable for exactly the RUN cycles.
    kernel_ce_d = (state_d == ST_RUN);
    done_d      = (state_d == ST_FINISH);
    unique case (state_q)
      ST_RUN: begin
        pending_d   = port_ce;
        we_d        = port_we;
        addr_d      = port_addr;
        dat_d       = port_d;
        done_pend_d = kernel_done & (|port_ce);
      end
      ST_ISSUE: begin
        if (sel_we) begin
          wr_req_d  = 1'b1;
          wr_addr_d = write_base + sel_off;
          wr_size_d = xfer_size;
          wr_data_d = sel_dat;
        end else begin
          rd_req_d  = 1'b1;
          rd_addr_d = read_base + sel_off;
          rd_size_d = xfer_size;
        end
      end
      ST_WAIT: begin
        if (ready_hit) begin
          pending_d = pend_clr;
          if (!sel_we) port_q_d[sel*DATA_WID +: DATA_WID] = mem.rd_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset) begin
      pending_q   <= '0;
      done_pend_q <= 1'b0;
      kernel_ce_q <= 1'b1;
      done_q      <= 1'b0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      rd_size_q   <= '0;
      wr_size_q   <= '0;
      port_q_q    <= '0;
    end else begin
      pending_q   <= pending_d;
      done_pend_q <= done_pend_d;
      kernel_ce_q <= kernel_ce_d;
      done_q      <= done_d;
      rd_req_q    <= rd_req_d;
      wr_req_q    <= wr_req_d;
      rd_addr_q   <= rd_addr_d;
      wr_addr_q   <= wr_addr_d;
      rd_size_q   <= rd_size_d;
      wr_size_q   <= wr_size_d;
      port_q_q    <= port_q_d;
    end
  end

  // Captured port fields are qualified by pending_q, so they need no reset.
  always_ff @(posedge mod_clk) begin
    we_q      <= we_d;
    addr_q    <= addr_d;
    dat_q     <= dat_d;
    wr_data_q <= wr_data_d;
  end

  assign kernel_ce   = kernel_ce_q;
  assign done        = done_q;
  assign port_q      = port_q_q;
  assign mem.rd_req  = rd_req_q;
  assign mem.rd_addr = rd_addr_q;
  assign mem.rd_size = rd_size_q;
  assign mem.wr_req  = wr_req_q;
  assign mem.wr_addr = wr_addr_q;
  assign mem.wr_size = wr_size_q;
  assign mem.wr_data = wr_data_q;

`ifdef MEM_BRIDGE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [31:0] access_count_q, access_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    access_count_d = access_count_q;
    stall_count_d  = stall_count_q;
    if ((state_q == ST_WAIT) && ready_hit) access_count_d = sat_inc(access_count_q);
    if (!kernel_ce_q && (state_q != ST_HALT)) stall_count_d = sat_inc(stall_count_q);
  end

  always_ff @(posedge mod_clk or posedge reset) begin
    if (reset) begin
      access_count_q <= '0;
      stall_count_q  <= '0;
    end else begin
      access_count_q <= access_count_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign access_count = access_count_q;
  assign stall_count  = stall_count_q;
`else
  assign access_count = '0;
  assign stall_count  = '0;
`endif
endmodule

// File: tb/tb_mem_port_bridge.sv
// tb_mem_port_bridge
//   Drives kernel port accesses against a 4-port mem_port_bridge, models the
//   external memory (with programmable response delay), and checks every
//   issued request against a queue of expected transactions pushed when the
//   kernel stimulus is driven.
module tb_mem_port_bridge;
  localparam int NP = 4;
  localparam int AW = 14;
  localparam int DW = 32;

  logic             mod_clk = 1'b0;
  logic             reset;
  logic [63:0]      read_base, write_base, xfer_size;
  logic [NP-1:0]    port_ce, port_we;
  logic [NP*AW-1:0] port_addr;
  logic [NP*DW-1:0] port_d, port_q;
  logic             kernel_ce, kernel_done, done;
  logic [31:0]      access_count, stall_count;

  always #5 mod_clk = ~mod_clk;

  mem_port_bridge_if #(.DATA_WID(DW)) mem_if ();

  mem_port_bridge #(
    .NUM_PORTS(NP), .ADDR_WID(AW), .DATA_WID(DW), .ADDR_SHIFT(2)
  ) dut (
    .mod_clk(mod_clk), .reset(reset),
    .read_base(read_base), .write_base(write_base), .xfer_size(xfer_size),
    .port_ce(port_ce), .port_we(port_we), .port_addr(port_addr),
    .port_d(port_d), .port_q(port_q),
    .kernel_ce(kernel_ce), .kernel_done(kernel_done),
    .mem(mem_if),
    .done(done), .access_count(access_count), .stall_count(stall_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [63:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] ref_mem [logic [63:0]];
  logic [31:0] dev_mem [logic [63:0]];
  logic [31:0] exp_pq  [NP];

  function automatic logic [31:0] fill(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  int cyc = 0;
  always @(posedge mod_clk) cyc <= cyc + 1;

  // Memory engine model
  int          rsp_delay = 1;
  int          rsp_cnt   = 0;
  bit          rsp_wr    = 0;
  logic [31:0] rsp_data  = '0;
  int          n_rd = 0, n_wr = 0, ready_cyc = 0;
  bit          prev_req = 0;

  initial begin : responder
    txn_t t;
    mem_if.rd_ready = 1'b0;
    mem_if.wr_ready = 1'b0;
    mem_if.rd_data  = '0;
    forever begin
      @(negedge mod_clk);
      mem_if.rd_ready = 1'b0;
      mem_if.wr_ready = 1'b0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          ready_cyc = cyc;
          if (rsp_wr) mem_if.wr_ready = 1'b1;
          else begin
            mem_if.rd_data  = rsp_data;
            mem_if.rd_ready = 1'b1;
          end
        end
      end
      if (mem_if.rd_req === 1'b1 || mem_if.wr_req === 1'b1) begin
        check_val("req_single_cycle", 64'(prev_req), 64'd0);
        check_val("one_outstanding", 64'(rsp_cnt), 64'd0);
        if (exp_q.size() == 0) check_val("unexpected_req", 64'd1, 64'd0);
        else begin
          t = exp_q.pop_front();
          if (mem_if.wr_req === 1'b1) begin
            n_wr++;
            check_val("req_kind_wr", 64'd1, 64'(t.is_wr));
            check_val("wr_addr", mem_if.wr_addr, t.addr);
            check_val("wr_size", mem_if.wr_size, xfer_size);
            check_val("wr_data", 64'(mem_if.wr_data), 64'(t.data));
            dev_mem[mem_if.wr_addr] = mem_if.wr_data;
            rsp_wr = 1'b1;
          end else begin
            n_rd++;
            check_val("req_kind_rd", 64'd0, 64'(t.is_wr));
            check_val("rd_addr", mem_if.rd_addr, t.addr);
            check_val("rd_size", mem_if.rd_size, xfer_size);
            rsp_wr   = 1'b0;
            rsp_data = dev_mem.exists(mem_if.rd_addr) ? dev_mem[mem_if.rd_addr]
                                                      : fill(mem_if.rd_addr);
          end
          rsp_cnt = rsp_delay;
        end
      end
      prev_req = (mem_if.rd_req === 1'b1) || (mem_if.wr_req === 1'b1);
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset       = 1'b1;
    port_ce     = '0;
    port_we     = '0;
    port_addr   = '0;
    port_d      = '0;
    kernel_done = 1'b0;
    repeat (2) @(negedge mod_clk);
    reset = 1'b0;
    for (int i = 0; i < NP; i++) exp_pq[i] = '0;
  endtask

  task automatic wait_ce(input string tag);
    int waited;
    waited = 0;
    while (kernel_ce !== 1'b1 && waited < 300) begin
      @(negedge mod_clk);
      waited++;
    end
    if (kernel_ce !== 1'b1) check_val({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  // One kernel-enabled edge with the given port activity; the expected
  // transactions are queued in ascending port order.
  task automatic kaccess(input logic [NP-1:0] ce, input logic [NP-1:0] we,
                         input logic [NP*AW-1:0] pa, input logic [NP*DW-1:0] pd,
                         input bit kd);
    txn_t t;
    wait_ce("ce_before_access");
    port_ce = ce; port_we = we; port_addr = pa; port_d = pd; kernel_done = kd;
    for (int i = 0; i < NP; i++) begin
      if (ce[i]) begin
        t.is_wr = we[i];
        t.addr  = (we[i] ? write_base : read_base) + 64'(pa[i*AW +: AW]) * 64'd4;
        if (we[i]) begin
          t.data = pd[i*DW +: DW];
          ref_mem[t.addr] = t.data;
        end else begin
          t.data = '0;
          exp_pq[i] = ref_mem.exists(t.addr) ? ref_mem[t.addr] : fill(t.addr);
        end
        exp_q.push_back(t);
      end
    end
    @(negedge mod_clk);
    port_ce = '0; port_we = '0; kernel_done = 1'b0;
    if (ce != '0) check_val("ce_drop", 64'(kernel_ce), 64'd0);
  endtask

  task automatic check_pq(input string tag);
    for (int i = 0; i < NP; i++)
      check_val($sformatf("%s_port_q%0d", tag, i), 64'(port_q[i*DW +: DW]), 64'(exp_pq[i]));
  endtask

  initial begin : main
    int n_rd0, n_wr0, done_cnt, n_wr_at_done, cyc_rst, stall0;
    bit ce_seen, bad;
    read_base = '0; write_base = '0; xfer_size = 64'h40;
    do_reset();

    // Reset state
    check_val("rst_kernel_ce", 64'(kernel_ce), 64'd1);
    check_val("rst_done", 64'(done), 64'd0);
    check_val("rst_rd_req", 64'(mem_if.rd_req), 64'd0);
    check_val("rst_wr_req", 64'(mem_if.wr_req), 64'd0);
    check_val("rst_rd_addr", mem_if.rd_addr, 64'd0);
    check_val("rst_wr_addr", mem_if.wr_addr, 64'd0);
    check_val("rst_rd_size", mem_if.rd_size, 64'd0);
    check_val("rst_wr_size", mem_if.wr_size, 64'd0);
    check_val("rst_port_q", 64'(port_q[DW-1:0]) | 64'(port_q[NP*DW-1:DW]), 64'd0);
    check_val("rst_access_count", 64'(access_count), 64'd0);
    check_val("rst_stall_count", 64'(stall_count), 64'd0);

    // Single read, response after 3 cycles
    read_base = 64'h1000; rsp_delay = 3;
    dev_mem[64'h1014] = 32'hDEAD; ref_mem[64'h1014] = 32'hDEAD;
    kaccess(4'b0001, 4'b0000, {42'd0, 14'd5}, '0, 1'b0);
    wait_ce("single_read");
    check_val("single_ce_latency", 64'(cyc), 64'(ready_cyc + 1));
    check_val("single_rd_addr", mem_if.rd_addr, 64'h1014);
    check_val("single_port_q0", 64'(port_q[DW-1:0]), 64'hDEAD);
    check_pq("single");

    // Same-cycle write (port 0) then read (port 1) of the same word
    do_reset();
    read_base = 64'h2000; write_base = 64'h2000; rsp_delay = 1;
    kaccess(4'b0011, 4'b0001, {28'd0, 14'd3, 14'd3}, {96'd0, 32'd7}, 1'b0);
    wait_ce("dual");
    check_val("dual_rd_addr", mem_if.rd_addr, 64'h200C);
    check_val("dual_port_q1", 64'(port_q[2*DW-1:DW]), 64'd7);
    check_pq("dual");
`ifdef MEM_BRIDGE_STATS_EN
    check_val("dual_access_count", 64'(access_count), 64'd2);
`else
    check_val("dual_access_count", 64'(access_count), 64'd0);
`endif

    // kernel_done alone goes straight to FINISH
    do_reset();
    kernel_done = 1'b1;
    @(negedge mod_clk);
    kernel_done = 1'b0;
    check_val("kdone_done_hi", 64'(done), 64'd1);
    check_val("kdone_ce_lo", 64'(kernel_ce), 64'd0);
    @(negedge mod_clk);
    check_val("kdone_done_lo", 64'(done), 64'd0);

    // kernel_done together with a port-1 write
    do_reset();
    write_base = 64'h3000;
    n_wr0 = n_wr; done_cnt = 0; n_wr_at_done = -1; ce_seen = 0;
    kaccess(4'b0010, 4'b0010, {28'd0, 14'd9, 14'd0}, {64'd0, 32'h1234, 32'd0}, 1'b1);
    for (int k = 0; k < 30; k++) begin
      if (done === 1'b1) begin
        done_cnt++;
        if (n_wr_at_done < 0) n_wr_at_done = n_wr;
      end
      if (kernel_ce === 1'b1) ce_seen = 1;
      @(negedge mod_clk);
    end
    check_val("simdone_done_pulses", 64'(done_cnt), 64'd1);
    check_val("simdone_write_first", 64'(n_wr_at_done), 64'(n_wr0 + 1));
    check_val("simdone_ce_stays_0", 64'(ce_seen), 64'd0);
    // HALT ignores further kernel activity
    n_rd0 = n_rd; n_wr0 = n_wr; bad = 0; stall0 = stall_count;
    port_ce = 4'b0011; kernel_done = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge mod_clk);
      if (kernel_ce !== 1'b0 || done !== 1'b0) bad = 1;
    end
    port_ce = '0; kernel_done = 1'b0;
    repeat (3) @(negedge mod_clk);
    check_val("halt_quiet", 64'(bad), 64'd0);
    check_val("halt_no_req", 64'(n_rd + n_wr), 64'(n_rd0 + n_wr0));
    check_val("halt_no_stall", 64'(stall_count), 64'(stall0));

    // Reset in WAIT, then the abandoned read's ready arrives late
    do_reset();
    read_base = '0; rsp_delay = 40; n_rd0 = n_rd;
    kaccess(4'b0001, 4'b0000, {42'd0, 14'd1}, '0, 1'b0);
    repeat (3) @(negedge mod_clk);
    check_val("abandon_req_seen", 64'(n_rd), 64'(n_rd0 + 1));
    cyc_rst = cyc;
    do_reset();
    n_rd0 = n_rd; n_wr0 = n_wr;
    repeat (45) @(negedge mod_clk);
    check_val("stray_ready_sent", 64'(ready_cyc > cyc_rst), 64'd1);
    check_val("stray_port_q0", 64'(port_q[DW-1:0]), 64'd0);
    check_val("stray_kernel_ce", 64'(kernel_ce), 64'd1);
    check_val("stray_no_req", 64'(n_rd + n_wr), 64'(n_rd0 + n_wr0));
    rsp_delay = 1;

    // 64-bit address wrap
    do_reset();
    read_base = 64'hFFFF_FFFF_FFFF_FFF0;
    kaccess(4'b0100, 4'b0000, {14'd0, 14'd8, 28'd0}, '0, 1'b0);
    wait_ce("wrap");
    check_val("wrap_rd_addr", mem_if.rd_addr, 64'h0000_0000_0000_0010);
    check_pq("wrap");

    // All four ports read in one cycle
    do_reset();
    read_base = 64'h4000; n_rd0 = n_rd;
    kaccess(4'b1111, 4'b0000, {14'd13, 14'd12, 14'd11, 14'd10}, '0, 1'b0);
    wait_ce("quad");
    check_val("quad_rd_count", 64'(n_rd), 64'(n_rd0 + 4));
    check_pq("quad");
`ifdef MEM_BRIDGE_STATS_EN
    check_val("quad_stall_ge8", 64'(stall_count >= 32'd8), 64'd1);
    check_val("quad_access_count", 64'(access_count), 64'd4);
`else
    check_val("quad_stall_count", 64'(stall_count), 64'd0);
    check_val("quad_access_count", 64'(access_count), 64'd0);
`endif

    check_val("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
